t_frag_cfg: RTL and testbench

- Parametrised successor to the T_FRAG logic fragment.
- Generalised 2**SEL_W-input mux with a per-input inversion mask and an optional registered output.
- The mask is loaded at run time through a serial configuration chain with a bit counter, shadow register and atomic commit.
- The block sits inside the C_FRAG next to B_FRAG and provides a reconfigurable mux cell for the quicklogic logic tile.

---
 rtl/t_frag_cfg_if.sv | 31 +++
 rtl/t_frag_cfg.sv | 109 ++++++++++
 tb/tb_t_frag_cfg.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t_frag_cfg_if.sv
// Port bundle for one t_frag_cfg cell: serial configuration chain plus mux datapath.
// The cell is the slave; whatever drives the chain and the data inputs is the master.
interface t_frag_cfg_if #(
    parameter int SEL_W = 3
);
    localparam int N = 1 << SEL_W;

    // Chain protocol: every QCK edge with CFG_EN=1 shifts one bit (LSB first).
    // A burst ends with one mandatory CFG_EN=0 cycle, and that edge commits or flags the mask.
    logic             CFG_EN;
    logic             CFG_DI;
    logic             CFG_DO;
    logic             CFG_DONE;
    logic             CFG_ERR;
    logic [N-1:0]     D;
    logic [SEL_W-1:0] SEL;
    logic             TBS;
    logic             QEN;
    logic             XZ;
    logic [1:0]       cfg_state;

    modport master (
        output CFG_EN, CFG_DI, D, SEL, TBS, QEN,
        input  CFG_DO, CFG_DONE, CFG_ERR, XZ, cfg_state
    );

    modport slave (
        input  CFG_EN, CFG_DI, D, SEL, TBS, QEN,
        output CFG_DO, CFG_DONE, CFG_ERR, XZ, cfg_state
    );
endinterface

// File: rtl/t_frag_cfg.sv
// Reconfigurable 2**SEL_W-input mux cell with a per-input inversion mask.
// The mask is loaded serially into a shadow register and committed atomically at burst end.
module t_frag_cfg #(
    parameter int SEL_W   = 3,
    parameter bit REG_OUT = 1'b1
) (
    input logic         QCK,
    input logic         QRN,
    t_frag_cfg_if.slave bus
);
    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = $clog2(N + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N + 1);

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        SHIFT = 2'd1,
        CFGD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     shadow;
    logic [N-1:0]     active;
    logic [CNT_W-1:0] cnt;
    logic             prev_cfgd;
    logic             cfg_do;
    logic             cfg_done;
    logic             cfg_err;
    logic             burst_end;
    logic             commit;
    logic             zc;

    always_ff @(posedge QCK or negedge QRN) begin
        if (!QRN) begin
            state <= UNCFG;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNCFG, CFGD: begin
                if (bus.CFG_EN) state_nxt = SHIFT;
            end
            SHIFT: begin
                // A failed burst falls back to wherever the cell was before it started.
                if (!bus.CFG_EN) state_nxt = (cnt == CNT_FULL || prev_cfgd) ? CFGD : UNCFG;
            end
            default: state_nxt = UNCFG;
        endcase
    end

    always_comb begin
        burst_end     = (state == SHIFT) && !bus.CFG_EN;
        commit        = burst_end && (cnt == CNT_FULL);
        zc            = bus.TBS & cfg_done & (bus.D[bus.SEL] ^ active[bus.SEL]);
        bus.cfg_state = state;
    end

    always_ff @(posedge QCK or negedge QRN) begin
        if (!QRN) begin
            shadow    <= '0;
            active    <= '0;
            cnt       <= '0;
            prev_cfgd <= 1'b0;
            cfg_do    <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (bus.CFG_EN) begin
            shadow <= {bus.CFG_DI, shadow[N-1:1]};
            cfg_do <= shadow[0];
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (state != SHIFT) prev_cfgd <= (state == CFGD);
        end else if (burst_end) begin
            cnt <= '0;
            if (commit) begin
                active   <= shadow;
                cfg_done <= 1'b1;
                cfg_err  <= 1'b0;
            end else begin
                cfg_err  <= 1'b1;
            end
        end
    end

    assign bus.CFG_DO   = cfg_do;
    assign bus.CFG_DONE = cfg_done;
    assign bus.CFG_ERR  = cfg_err;

    generate
        if (REG_OUT) begin : g_reg_out
            logic xz_q;
            always_ff @(posedge QCK or negedge QRN) begin
                if (!QRN) begin
                    xz_q <= 1'b0;
                end else if (bus.QEN) begin
                    xz_q <= zc;
                end
            end
            assign bus.XZ = xz_q;
        end else begin : g_comb_out
            assign bus.XZ = zc;
        end
    endgenerate
endmodule

// File: tb/tb_t_frag_cfg.sv
// Directed bench for t_frag_cfg: a near/far registered pair on one chain plus a
// combinational cell that mirrors the near cell's inputs.
module tb_t_frag_cfg;
  logic QCK = 1'b0;
  logic QRN = 1'b0;
  logic far_en;
  int checks = 0;
  int errors = 0;

  localparam logic [7:0] MASK_A = 8'hA5;
  localparam logic [7:0] MASK_B = 8'h3C;

  always #5 QCK = ~QCK;

  t_frag_cfg_if #(.SEL_W(3)) ifb ();
  t_frag_cfg_if #(.SEL_W(3)) ifa ();
  t_frag_cfg_if #(.SEL_W(3)) ifc ();

  // far cell sits behind the near cell on the chain; comb cell mirrors the near cell
  assign ifa.CFG_EN = far_en;
  assign ifa.CFG_DI = ifb.CFG_DO;
  assign ifa.D      = ifb.D;
  assign ifa.SEL    = ifb.SEL;
  assign ifa.TBS    = ifb.TBS;
  assign ifa.QEN    = ifb.QEN;
  assign ifc.CFG_EN = ifb.CFG_EN;
  assign ifc.CFG_DI = ifb.CFG_DI;
  assign ifc.D      = ifb.D;
  assign ifc.SEL    = ifb.SEL;
  assign ifc.TBS    = ifb.TBS;
  assign ifc.QEN    = ifb.QEN;

  t_frag_cfg #(.SEL_W(3), .REG_OUT(1'b1)) u_near (.QCK(QCK), .QRN(QRN), .bus(ifb.slave));
  t_frag_cfg #(.SEL_W(3), .REG_OUT(1'b1)) u_far  (.QCK(QCK), .QRN(QRN), .bus(ifa.slave));
  t_frag_cfg #(.SEL_W(3), .REG_OUT(1'b0)) u_comb (.QCK(QCK), .QRN(QRN), .bus(ifc.slave));

  task automatic tick;
    @(posedge QCK);
    #1;
  endtask

  task automatic shift_mask(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ifb.CFG_EN = 1'b1;
      ifb.CFG_DI = bits[i];
      tick();
    end
    ifb.CFG_EN = 1'b0;
    ifb.CFG_DI = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    ifb.CFG_EN = 1'b0;
    ifb.CFG_DI = 1'b0;
    ifb.D      = 8'h00;
    ifb.SEL    = 3'd0;
    ifb.TBS    = 1'b0;
    ifb.QEN    = 1'b1;
    far_en     = 1'b0;
    QRN        = 1'b0;
    tick();
    tick();
    checks++;
    if ({ifb.cfg_state, ifb.XZ, ifb.CFG_DONE, ifb.CFG_ERR, ifb.CFG_DO} !== 6'b0) begin
      errors++;
      $display("FAIL reset_near got %b exp 000000",
               {ifb.cfg_state, ifb.XZ, ifb.CFG_DONE, ifb.CFG_ERR, ifb.CFG_DO});
    end
    QRN     = 1'b1;
    ifb.D   = 8'hFF;
    ifb.SEL = 3'd5;
    ifb.TBS = 1'b1;
    repeat (10) tick();
    checks++;
    if ({ifb.cfg_state, ifb.XZ, ifb.CFG_DONE, ifb.CFG_ERR, ifb.CFG_DO} !== 6'b0) begin
      errors++;
      $display("FAIL unconfigured_near got %b exp 000000",
               {ifb.cfg_state, ifb.XZ, ifb.CFG_DONE, ifb.CFG_ERR, ifb.CFG_DO});
    end
    checks++;
    if ({ifc.XZ, ifa.XZ, ifc.CFG_DONE, ifa.CFG_DONE} !== 4'b0) begin
      errors++;
      $display("FAIL unconfigured_others got %b exp 0000",
               {ifc.XZ, ifa.XZ, ifc.CFG_DONE, ifa.CFG_DONE});
    end
  endtask

  task automatic test_commit;
    logic [7:0] m;
    m = 8'b0010_0000;
    for (int i = 0; i < 8; i++) begin
      ifb.CFG_EN = 1'b1;
      ifb.CFG_DI = m[i];
      tick();
    end
    checks++;
    if ({ifb.cfg_state, ifb.CFG_DONE} !== 3'b010) begin
      errors++;
      $display("FAIL pre_commit got %b exp 010", {ifb.cfg_state, ifb.CFG_DONE});
    end
    ifb.CFG_EN = 1'b0;
    ifb.CFG_DI = 1'b0;
    tick();
    checks++;
    if ({ifb.cfg_state, ifb.CFG_DONE, ifb.CFG_ERR, ifb.XZ} !== 5'b10100) begin
      errors++;
      $display("FAIL commit_edge got %b exp 10100",
               {ifb.cfg_state, ifb.CFG_DONE, ifb.CFG_ERR, ifb.XZ});
    end
    ifb.D   = 8'h00;
    ifb.SEL = 3'd5;
    #1;
    checks++;
    if (ifc.XZ !== 1'b1) begin
      errors++;
      $display("FAIL comb_sel5 got %b exp 1", ifc.XZ);
    end
    tick();
    checks++;
    if (ifb.XZ !== 1'b1) begin
      errors++;
      $display("FAIL reg_sel5 got %b exp 1", ifb.XZ);
    end
    ifb.SEL = 3'd4;
    tick();
    checks++;
    if (ifb.XZ !== 1'b0) begin
      errors++;
      $display("FAIL reg_sel4 got %b exp 0", ifb.XZ);
    end
    ifb.SEL = 3'd5;
    ifb.TBS = 1'b0;
    tick();
    checks++;
    if ({ifb.XZ, ifc.XZ} !== 2'b00) begin
      errors++;
      $display("FAIL tbs_gate got %b exp 00", {ifb.XZ, ifc.XZ});
    end
    ifb.TBS = 1'b1;
    tick();
  endtask

  task automatic test_bad_length;
    shift_mask(16'h00FF, 7);
    checks++;
    if ({ifb.cfg_state, ifb.CFG_DONE, ifb.CFG_ERR} !== 4'b1011) begin
      errors++;
      $display("FAIL short_burst got %b exp 1011",
               {ifb.cfg_state, ifb.CFG_DONE, ifb.CFG_ERR});
    end
    ifb.SEL = 3'd5;
    tick();
    checks++;
    if (ifb.XZ !== 1'b1) begin
      errors++;
      $display("FAIL short_keep_sel5 got %b exp 1", ifb.XZ);
    end
    ifb.SEL = 3'd0;
    tick();
    checks++;
    if (ifb.XZ !== 1'b0) begin
      errors++;
      $display("FAIL short_keep_sel0 got %b exp 0", ifb.XZ);
    end
    shift_mask(16'h01FF, 9);
    checks++;
    if ({ifb.cfg_state, ifb.CFG_DONE, ifb.CFG_ERR} !== 4'b1011) begin
      errors++;
      $display("FAIL long_burst got %b exp 1011",
               {ifb.cfg_state, ifb.CFG_DONE, ifb.CFG_ERR});
    end
    tick();
    checks++;
    if (ifb.XZ !== 1'b0) begin
      errors++;
      $display("FAIL long_keep_sel0 got %b exp 0", ifb.XZ);
    end
    ifb.SEL = 3'd5;
    tick();
    checks++;
    if (ifb.XZ !== 1'b1) begin
      errors++;
      $display("FAIL long_keep_sel5 got %b exp 1", ifb.XZ);
    end
  endtask

  task automatic test_chain;
    logic [7:0] mb;
    mb = MASK_B;
    // far cell's bits go first: park them in the near cell's shadow
    shift_mask({8'h00, MASK_A}, 8);
    for (int t = 1; t <= 9; t++) begin
      ifb.CFG_EN = (t <= 8);
      ifb.CFG_DI = (t <= 8) ? mb[t-1] : 1'b0;
      far_en     = (t >= 2);
      tick();
    end
    far_en = 1'b0;
    tick();
    checks++;
    if ({ifb.CFG_DONE, ifb.CFG_ERR, ifa.CFG_DONE, ifa.CFG_ERR} !== 4'b1010) begin
      errors++;
      $display("FAIL chain_commit got %b exp 1010",
               {ifb.CFG_DONE, ifb.CFG_ERR, ifa.CFG_DONE, ifa.CFG_ERR});
    end
    ifb.D = 8'h00;
    for (int s = 0; s < 8; s++) begin
      ifb.SEL = s[2:0];
      tick();
      checks++;
      if ({ifa.XZ, ifb.XZ, ifc.XZ} !== {MASK_A[s], MASK_B[s], MASK_B[s]}) begin
        errors++;
        $display("FAIL chain_sel%0d got %b exp %b", s, {ifa.XZ, ifb.XZ, ifc.XZ},
                 {MASK_A[s], MASK_B[s], MASK_B[s]});
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    ifb.SEL = 3'd2;
    ifb.D   = 8'h00;
    tick();
    for (int i = 0; i < 4; i++) begin
      ifb.CFG_EN = 1'b1;
      ifb.CFG_DI = 1'b1;
      tick();
    end
    checks++;
    if ({ifb.cfg_state, ifb.XZ, ifb.CFG_DONE} !== 4'b0111) begin
      errors++;
      $display("FAIL mid_burst_old_mask got %b exp 0111",
               {ifb.cfg_state, ifb.XZ, ifb.CFG_DONE});
    end
    #2;
    QRN = 1'b0;
    #1;
    checks++;
    if ({ifb.cfg_state, ifb.XZ, ifb.CFG_DONE, ifb.CFG_ERR, ifb.CFG_DO} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_near got %b exp 000000",
               {ifb.cfg_state, ifb.XZ, ifb.CFG_DONE, ifb.CFG_ERR, ifb.CFG_DO});
    end
    checks++;
    if ({ifa.XZ, ifa.CFG_DONE, ifc.XZ, ifc.CFG_DONE} !== 4'b0) begin
      errors++;
      $display("FAIL async_reset_others got %b exp 0000",
               {ifa.XZ, ifa.CFG_DONE, ifc.XZ, ifc.CFG_DONE});
    end
    ifb.CFG_EN = 1'b0;
    ifb.CFG_DI = 1'b0;
    tick();
    QRN = 1'b1;
    tick();
    shift_mask(16'h0081, 8);
    checks++;
    if ({ifb.cfg_state, ifb.CFG_DONE, ifb.CFG_ERR} !== 4'b1010) begin
      errors++;
      $display("FAIL post_reset_commit got %b exp 1010",
               {ifb.cfg_state, ifb.CFG_DONE, ifb.CFG_ERR});
    end
    ifb.SEL = 3'd0;
    tick();
    checks++;
    if (ifb.XZ !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_sel0 got %b exp 1", ifb.XZ);
    end
    ifb.SEL = 3'd3;
    tick();
    checks++;
    if (ifb.XZ !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_sel3 got %b exp 0", ifb.XZ);
    end
    ifb.SEL = 3'd7;
    tick();
    checks++;
    if (ifb.XZ !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_sel7 got %b exp 1", ifb.XZ);
    end
  endtask

  task automatic test_qen_hold;
    ifb.SEL = 3'd0;
    ifb.D   = 8'h00;
    ifb.QEN = 1'b1;
    tick();
    ifb.QEN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifb.D = (i % 2 == 0) ? 8'h01 : 8'h00;
      #1;
      checks++;
      if (ifc.XZ !== ~ifb.D[0]) begin
        errors++;
        $display("FAIL comb_follow_%0d got %b exp %b", i, ifc.XZ, ~ifb.D[0]);
      end
      tick();
      checks++;
      if (ifb.XZ !== 1'b1) begin
        errors++;
        $display("FAIL qen_hold_%0d got %b exp 1", i, ifb.XZ);
      end
    end
    ifb.QEN = 1'b1;
    ifb.D   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ifb.CFG_EN = 1'b1;
      ifb.CFG_DI = (i != 0 && i != 7);
      tick();
    end
    ifb.CFG_EN = 1'b0;
    ifb.CFG_DI = 1'b0;
    #1;
    checks++;
    if ({ifb.XZ, ifc.XZ} !== 2'b11) begin
      errors++;
      $display("FAIL before_commit got %b exp 11", {ifb.XZ, ifc.XZ});
    end
    tick();
    checks++;
    if ({ifb.XZ, ifc.XZ} !== 2'b10) begin
      errors++;
      $display("FAIL on_commit_edge got %b exp 10", {ifb.XZ, ifc.XZ});
    end
    tick();
    checks++;
    if ({ifb.XZ, ifc.XZ} !== 2'b00) begin
      errors++;
      $display("FAIL after_commit got %b exp 00", {ifb.XZ, ifc.XZ});
    end
  endtask

  task automatic test_back_to_back;
    ifb.SEL = 3'd0;
    ifb.D   = 8'h00;
    shift_mask(16'h000F, 8);
    checks++;
    if ({ifc.XZ, ifb.CFG_DONE, ifb.CFG_ERR} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_first got %b exp 110", {ifc.XZ, ifb.CFG_DONE, ifb.CFG_ERR});
    end
    shift_mask(16'h00F0, 8);
    checks++;
    if ({ifc.XZ, ifb.CFG_DONE, ifb.CFG_ERR} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_second_sel0 got %b exp 010", {ifc.XZ, ifb.CFG_DONE, ifb.CFG_ERR});
    end
    ifb.SEL = 3'd7;
    #1;
    checks++;
    if (ifc.XZ !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_sel7 got %b exp 1", ifc.XZ);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_commit();
    test_bad_length();
    test_chain();
    test_reset_mid_burst();
    test_qen_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
